// File: rtl/voice_scheduler.sv
// voice_scheduler: allocates MIDI note events to DDS voice slots (retrigger, free or
// steal-oldest) and emits one slot-RAM write per event, plus clear sweeps after reset/panic.
module voice_scheduler #(
  parameter int VOICES   = 16,
  parameter int VOICE_AW = 4
) (
  input  logic                i_clk,
  input  logic                i_res_n,
  input  logic                i_ev_valid,
  output logic                o_ev_ready,
  input  logic                i_ev_on,
  input  logic [3:0]          i_ev_ch,
  input  logic [6:0]          i_ev_note,
  input  logic [6:0]          i_ev_vel,
  input  logic                i_all_off,
  output logic                o_wr_en,
  output logic [VOICE_AW-1:0] o_wr_addr,
  output logic [15:0]         o_wr_data,
  output logic [VOICES-1:0]   o_active,
  output logic                o_steal
);

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_SEARCH = 2'd2,
    ST_WRITE  = 2'd3
  } state_t;

  localparam logic [VOICE_AW-1:0] LAST_IDX = VOICE_AW'(VOICES - 1);
  localparam logic [VOICE_AW-1:0] ONE_IDX  = VOICE_AW'(1);
  localparam logic [VOICE_AW-1:0] ZERO_IDX = VOICE_AW'(0);
  localparam logic [7:0]          AGE_MAX  = 8'd255;

  state_t              state_r;
  state_t              state_next_s;
  logic                ready_r;
  logic [VOICE_AW-1:0] idx_r;

  logic                ev_on_r;
  logic [3:0]          ev_ch_r;
  logic [6:0]          ev_note_r;
  logic [6:0]          ev_vel_r;

  logic [VOICES-1:0]   active_r;
  logic [3:0]          ch_r   [VOICES];
  logic [6:0]          note_r [VOICES];
  logic [7:0]          age_r  [VOICES];

  logic                match_found_r;
  logic                free_found_r;
  logic [VOICE_AW-1:0] match_idx_r;
  logic [VOICE_AW-1:0] free_idx_r;
  logic [VOICE_AW-1:0] old_idx_r;
  logic [7:0]          old_age_r;

  logic                wr_en_r;
  logic                steal_r;
  logic [VOICE_AW-1:0] wr_addr_r;
  logic [15:0]         wr_data_r;

  logic                accept_s;
  logic                hit_s;
  logic                steal_s;
  logic [VOICE_AW-1:0] target_s;

  assign o_ev_ready = ready_r;
  assign o_wr_en    = wr_en_r;
  assign o_wr_addr  = wr_addr_r;
  assign o_wr_data  = wr_data_r;
  assign o_active   = active_r;
  assign o_steal    = steal_r;

  // Next-state decode, scan compare for the current slot and final target selection
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    hit_s        = active_r[idx_r] && (ch_r[idx_r] == ev_ch_r) && (note_r[idx_r] == ev_note_r);
    steal_s      = ev_on_r && !match_found_r && !free_found_r;
    if (match_found_r) begin
      target_s = match_idx_r;
    end else if (free_found_r) begin
      target_s = free_idx_r;
    end else begin
      target_s = old_idx_r;
    end
    case (state_r)
      ST_CLEAR: begin
        if (idx_r == LAST_IDX) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_CLEAR;
        end
      end
      ST_IDLE: begin
        // Panic wins over a coincident event, which is then simply not accepted
        if (i_all_off) begin
          state_next_s = ST_CLEAR;
        end else if (i_ev_valid) begin
          accept_s     = 1'b1;
          state_next_s = ST_SEARCH;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (idx_r == LAST_IDX) begin
          state_next_s = ST_WRITE;
        end else begin
          state_next_s = ST_SEARCH;
        end
      end
      ST_WRITE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_CLEAR;
      end
    endcase
  end

  // State register and ready flag
  always_ff @(posedge i_clk) begin
    if (!i_res_n) begin
      state_r <= ST_CLEAR;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ready_r <= (state_next_s == ST_IDLE);
    end
  end

  // Slot table, scan candidates, event latch and write port
  always_ff @(posedge i_clk) begin
    if (!i_res_n) begin
      idx_r         <= ZERO_IDX;
      ev_on_r       <= 1'b0;
      ev_ch_r       <= 4'd0;
      ev_note_r     <= 7'd0;
      ev_vel_r      <= 7'd0;
      active_r      <= '0;
      match_found_r <= 1'b0;
      free_found_r  <= 1'b0;
      match_idx_r   <= ZERO_IDX;
      free_idx_r    <= ZERO_IDX;
      old_idx_r     <= ZERO_IDX;
      old_age_r     <= 8'd0;
      wr_en_r       <= 1'b0;
      steal_r       <= 1'b0;
      wr_addr_r     <= ZERO_IDX;
      wr_data_r     <= 16'h0000;
      for (int i = 0; i < VOICES; i++) begin
        ch_r[i]   <= 4'd0;
        note_r[i] <= 7'd0;
        age_r[i]  <= 8'd0;
      end
    end else begin
      wr_en_r <= 1'b0;
      steal_r <= 1'b0;
      case (state_r)
        ST_CLEAR: begin
          wr_en_r   <= 1'b1;
          wr_addr_r <= idx_r;
          wr_data_r <= 16'h0000;
          idx_r     <= (idx_r == LAST_IDX) ? ZERO_IDX : idx_r + ONE_IDX;
        end
        ST_IDLE: begin
          idx_r <= ZERO_IDX;
          if (i_all_off) begin
            active_r <= '0;
            for (int i = 0; i < VOICES; i++) begin
              age_r[i] <= 8'd0;
            end
          end else if (accept_s) begin
            // A note-on with zero velocity is a note-off
            ev_on_r       <= i_ev_on && (i_ev_vel != 7'd0);
            ev_ch_r       <= i_ev_ch;
            ev_note_r     <= i_ev_note;
            ev_vel_r      <= i_ev_vel;
            match_found_r <= 1'b0;
            free_found_r  <= 1'b0;
            match_idx_r   <= ZERO_IDX;
            free_idx_r    <= ZERO_IDX;
            old_idx_r     <= ZERO_IDX;
            old_age_r     <= 8'd0;
          end
        end
        ST_SEARCH: begin
          if (hit_s && !match_found_r) begin
            match_found_r <= 1'b1;
            match_idx_r   <= idx_r;
          end
          if (!active_r[idx_r] && !free_found_r) begin
            free_found_r <= 1'b1;
            free_idx_r   <= idx_r;
          end
          // Strict compare keeps the lowest index on equal ages
          if (age_r[idx_r] > old_age_r) begin
            old_age_r <= age_r[idx_r];
            old_idx_r <= idx_r;
          end
          idx_r <= (idx_r == LAST_IDX) ? ZERO_IDX : idx_r + ONE_IDX;
        end
        ST_WRITE: begin
          idx_r <= ZERO_IDX;
          if (ev_on_r) begin
            wr_en_r   <= 1'b1;
            steal_r   <= steal_s;
            wr_addr_r <= target_s;
            wr_data_r <= {1'b1, ev_note_r, 1'b0, ev_vel_r};
            for (int i = 0; i < VOICES; i++) begin
              if (VOICE_AW'(i) == target_s) begin
                active_r[i] <= 1'b1;
                ch_r[i]     <= ev_ch_r;
                note_r[i]   <= ev_note_r;
                age_r[i]    <= 8'd0;
              end else if (active_r[i] && (age_r[i] != AGE_MAX)) begin
                age_r[i] <= age_r[i] + 8'd1;
              end
            end
          end else if (match_found_r) begin
            wr_en_r               <= 1'b1;
            wr_addr_r             <= match_idx_r;
            wr_data_r             <= {1'b0, ev_note_r, 8'd0};
            active_r[match_idx_r] <= 1'b0;
            age_r[match_idx_r]    <= 8'd0;
          end
        end
        default: begin
          idx_r <= ZERO_IDX;
        end
      endcase
    end
  end

endmodule
